// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and helpers for the UART transmit scheduler: FSM states,
// the per-word frame configuration record and its legality check.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ARM  = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] frame_length;
        logic [1:0] parity;
        logic       stop_bits;
    } tx_cfg_t;

    localparam logic [3:0] FRAME_LEN_MIN  = 4'd5;
    localparam logic [3:0] FRAME_LEN_MAX  = 4'd8;
    localparam logic [1:0] PARITY_ILLEGAL = 2'b01;

    // Odd-without-enable parity is meaningless to the transmitter, so it is rejected too.
    function automatic logic cfg_legal(input tx_cfg_t cfg);
        return (cfg.frame_length >= FRAME_LEN_MIN) &&
               (cfg.frame_length <= FRAME_LEN_MAX) &&
               (cfg.parity != PARITY_ILLEGAL);
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Write-side and transmitter-side handshake bundle of the TX scheduler.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface uart_tx_scheduler_if
    import uart_tx_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  tx_tick;
    logic                  tx_detect;
    logic [DATA_WIDTH-1:0] tx_write_data;
    logic [3:0]            tx_frame_length;
    logic [1:0]            tx_parity;
    logic                  tx_stop_bits;
    logic                  tx_done;

    modport master (
        output wr_valid, wr_data, tx_tick, tx_done,
        input  wr_ready, tx_detect, tx_write_data, tx_frame_length, tx_parity, tx_stop_bits
    );

    modport slave (
        input  wr_valid, wr_data, tx_tick, tx_done,
        output wr_ready, tx_detect, tx_write_data, tx_frame_length, tx_parity, tx_stop_bits
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO with registered occupancy and ready flag.
// A push while full is still taken when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 4,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [CW-1:0]         count_o,
    output logic                  ready_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  ready_q;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    assign pop_ok_s  = pop_i && (count_q != '0);
    assign push_ok_s = push_i && ((count_q != CW'(DEPTH)) || pop_ok_s);
    assign rdata_o   = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign ready_o   = ready_q;

    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            ready_q <= (count_d != CW'(DEPTH));
        end
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Feeds buffered words to the UART transmitter one at a time, holding data and
// frame config stable per word and watching for completion or a stall.
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter  int DATA_WIDTH    = 32,
    parameter  int FIFO_DEPTH    = 4,
    parameter  int TIMEOUT_TICKS = 255,
    localparam int CW            = $clog2(FIFO_DEPTH + 1),
    localparam int TW            = $clog2(TIMEOUT_TICKS + 1)
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    uart_tx_scheduler_if.slave    bus,
    input  logic                  cfg_enable,
    input  logic [3:0]            cfg_frame_length,
    input  logic [1:0]            cfg_parity,
    input  logic                  cfg_stop_bits,
    input  logic                  err_clr,
    output logic                  busy,
    output logic [CW-1:0]         fifo_count,
    output logic                  cfg_error,
    output logic                  timeout_err
);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_LOAD = ST_LOAD;
    localparam logic [1:0] S_ARM  = ST_ARM;
    localparam logic [1:0] S_RUN  = ST_RUN;

    logic [1:0]            state_q, state_d;
    logic [TW-1:0]         ticks_q, ticks_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    tx_cfg_t               cfg_q, cfg_d;
    tx_cfg_t               cfg_in_s;
    logic                  detect_q, busy_q;
    logic                  cfg_err_q, cfg_err_d;
    logic                  to_err_q, to_err_d;
    logic                  cfg_set_s, to_set_s, pop_s;
    logic [DATA_WIDTH-1:0] head_s;

    assign cfg_in_s = '{frame_length: cfg_frame_length, parity: cfg_parity, stop_bits: cfg_stop_bits};

    uart_tx_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (PCLK),
        .rst_ni  (PRESETn),
        .push_i  (bus.wr_valid),
        .pop_i   (pop_s),
        .wdata_i (bus.wr_data),
        .rdata_o (head_s),
        .count_o (fifo_count),
        .ready_o (bus.wr_ready)
    );

    // Next-state logic for the word sequencer, tick counter and sticky flags.
    always_comb begin
        state_d   = state_q;
        ticks_d   = ticks_q;
        data_d    = data_q;
        cfg_d     = cfg_q;
        cfg_set_s = 1'b0;
        to_set_s  = 1'b0;
        pop_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((fifo_count != '0) && cfg_enable) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                pop_s  = 1'b1;
                data_d = head_s;
                cfg_d  = cfg_in_s;
                if (cfg_legal(cfg_in_s)) begin
                    state_d = S_ARM;
                end else begin
                    cfg_set_s = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_ARM: begin
                ticks_d = '0;
                if (bus.tx_tick) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_RUN: begin
                // Completion is only trusted on baud ticks.
                if (bus.tx_tick) begin
                    if (bus.tx_done) begin
                        state_d = S_IDLE;
                    end else begin
                        ticks_d = ticks_q + TW'(1);
                        if (ticks_d == TW'(TIMEOUT_TICKS)) begin
                            to_set_s = 1'b1;
                            state_d  = S_IDLE;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        cfg_err_d = cfg_set_s || (cfg_err_q && !err_clr);
        to_err_d  = to_set_s  || (to_err_q  && !err_clr);
    end

    // State, held word/config and status registers.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            ticks_q   <= '0;
            data_q    <= '0;
            cfg_q     <= '{frame_length: 4'd8, parity: 2'b00, stop_bits: 1'b0};
            detect_q  <= 1'b0;
            busy_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ticks_q   <= ticks_d;
            data_q    <= data_d;
            cfg_q     <= cfg_d;
            detect_q  <= (state_d == S_ARM);
            busy_q    <= (state_d != S_IDLE);
            cfg_err_q <= cfg_err_d;
            to_err_q  <= to_err_d;
        end
    end

    assign bus.tx_detect       = detect_q;
    assign bus.tx_write_data   = data_q;
    assign bus.tx_frame_length = cfg_q.frame_length;
    assign bus.tx_parity       = cfg_q.parity;
    assign bus.tx_stop_bits    = cfg_q.stop_bits;
    assign busy                = busy_q;
    assign cfg_error           = cfg_err_q;
    assign timeout_err         = to_err_q;
endmodule
